branch_predictor_gshare: RTL

- Parametrised successor to the core's bimodal predictor, sitting between IF (pc), ID (decode/imm) and EX (resolution).
- Predicts conditional branches with a 2-bit saturating PHT, indexed by pc XOR a global history register (GHR).
- Resolves jal, and resolves jalr through a circular return-address stack (RAS) with underflow fallback.
- Drives next-fetch target_pc, mispredict flush (predict_fail) and sepc capture on exception.

---
 rtl/branch_predictor_gshare_if.sv | 46 ++++
 rtl/branch_predictor_gshare.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare_if.sv
// Front-end interface of the gshare branch predictor.
// Groups the IF/ID request fields, the EX resolution feedback and the
// predictor results into one bundle.
//   master : fetch/decode/execute side (drives requests, reads predictions)
//   slave  : predictor side (reads requests, drives predictions)
interface branch_predictor_gshare_if #(
  parameter int XLEN      = 32,
  parameter int PHT_IDX_W = 10
);
  // IF / ID request
  logic                 branch;
  logic                 predict;
  logic                 ujtype;
  logic [4:0]           rs1;
  logic [4:0]           rd;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      imm;
  logic [XLEN-1:0]      pc;
  logic                 excp;
  // EX resolution
  logic [XLEN-1:0]      old_pc;
  logic [XLEN-1:0]      old_branch_pc;
  logic [PHT_IDX_W-1:0] old_pred_idx;
  logic                 old_predict;
  logic                 old_actual;
  logic                 old_branch;
  // predictor results
  logic [XLEN-1:0]      target_pc;
  logic                 predict_result;
  logic                 predict_fail;
  logic [PHT_IDX_W-1:0] pred_idx;
  logic [XLEN-1:0]      sepc;
  logic                 ras_empty;

  modport master (
    output branch, predict, ujtype, rs1, rd, rs1_data, imm, pc, excp,
           old_pc, old_branch_pc, old_pred_idx, old_predict, old_actual, old_branch,
    input  target_pc, predict_result, predict_fail, pred_idx, sepc, ras_empty
  );

  modport slave (
    input  branch, predict, ujtype, rs1, rd, rs1_data, imm, pc, excp,
           old_pc, old_branch_pc, old_pred_idx, old_predict, old_actual, old_branch,
    output target_pc, predict_result, predict_fail, pred_idx, sepc, ras_empty
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare / bimodal branch predictor with a circular return-address stack.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bp    : branch_predictor_gshare_if.slave (requests, resolution, results)
// Build option:
//   BP_GSHARE_EN defined   -> PHT index = pc word index XOR global history
//   BP_GSHARE_EN undefined -> history register removed, pure bimodal index
module branch_predictor_gshare #(
  parameter int              XLEN      = 32,
  parameter int              PHT_IDX_W = 10,
  parameter int              GHR_W     = 8,
  parameter int              RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] EXCP_ADDR = 32'h1C09_0000
) (
  input logic                     clk,
  input logic                     rst_n,
  branch_predictor_gshare_if.slave bp
);

  localparam int PHT_SIZE  = 1 << PHT_IDX_W;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = RAS_PTR_W + 1;

  logic                 boot_q, boot_d;
  logic [1:0]           pht_q [PHT_SIZE];
  logic [1:0]           pht_d [PHT_SIZE];
  logic [XLEN-1:0]      ras_q [RAS_DEPTH];
  logic [XLEN-1:0]      ras_d [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ras_top_q, ras_top_d;   // next free slot
  logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic [XLEN-1:0]      sepc_q, sepc_d;

  logic [PHT_IDX_W-1:0] idx;
  logic [RAS_PTR_W-1:0] ras_last;
  logic [XLEN-1:0]      pc_plus4, pc_plus_imm, jalr_tgt;
  logic                 empty, fail, is_call, is_ret, ras_upd;
  logic [1:0]           ctr;

  // Resolution-side pc is not needed as an index source; the index travels
  // with the branch instead.
  logic unused_old_branch_pc;
  assign unused_old_branch_pc = ^bp.old_branch_pc;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;
  assign idx = bp.pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
`else
  logic [GHR_W-1:0] unused_ghr;
  assign unused_ghr = '0;
  assign idx = bp.pc[PHT_IDX_W+1:2];
`endif

  assign pc_plus4    = bp.pc + XLEN'(4);
  assign pc_plus_imm = bp.pc + bp.imm;
  assign jalr_tgt    = (bp.rs1_data + bp.imm) & ~XLEN'(1);
  assign ras_last    = ras_top_q - RAS_PTR_W'(1);
  assign empty       = (ras_cnt_q == '0);
  assign fail        = (bp.old_predict != bp.old_actual);
  assign is_call     = (bp.rd == 5'd1);
  assign is_ret      = (bp.rs1 == 5'd1);

  assign bp.pred_idx     = idx;
  assign bp.predict_fail = fail;
  assign bp.sepc         = sepc_q;
  assign bp.ras_empty    = empty;

  // Prediction path (zero latency).
  always_comb begin
    bp.target_pc      = '0;
    bp.predict_result = 1'b0;
    if (boot_q) begin
      if (bp.excp) begin
        bp.target_pc = EXCP_ADDR;
      end else if (fail) begin
        bp.target_pc      = bp.old_pc;
        bp.predict_result = bp.old_actual;
      end else begin
        unique case ({bp.branch, bp.predict})
          2'b11: begin
            bp.predict_result = pht_q[idx][1];
            bp.target_pc      = pht_q[idx][1] ? pc_plus_imm : pc_plus4;
          end
          2'b10: begin
            bp.predict_result = 1'b1;
            if (bp.ujtype)              bp.target_pc = pc_plus_imm;
            else if (is_ret && !empty)  bp.target_pc = ras_q[ras_last];
            else                        bp.target_pc = jalr_tgt;
          end
          default: bp.target_pc = pc_plus4;
        endcase
      end
    end
  end

  assign ras_upd = boot_q && bp.branch && !bp.predict && !fail && !bp.excp;
  assign ctr     = pht_q[bp.old_pred_idx];

  // State update.
  always_comb begin
    boot_d    = 1'b1;
    pht_d     = pht_q;
    ras_d     = ras_q;
    ras_top_d = ras_top_q;
    ras_cnt_d = ras_cnt_q;
    sepc_d    = sepc_q;
`ifdef BP_GSHARE_EN
    ghr_d     = ghr_q;
`endif
    if (boot_q) begin
      if (bp.old_branch) begin
        if (bp.old_actual && ctr != 2'b11)      pht_d[bp.old_pred_idx] = ctr + 2'b01;
        else if (!bp.old_actual && ctr != 2'b00) pht_d[bp.old_pred_idx] = ctr - 2'b01;
`ifdef BP_GSHARE_EN
        ghr_d = {ghr_q[GHR_W-2:0], bp.old_actual};
`endif
      end
      if (ras_upd) begin
        if (is_call && (!is_ret || empty)) begin
          // Push; when full the write lands on the oldest slot.
          ras_d[ras_top_q] = pc_plus4;
          ras_top_d        = ras_top_q + RAS_PTR_W'(1);
          if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
        end else if (is_call && is_ret) begin
          ras_d[ras_last] = pc_plus4;
        end else if (is_ret && !empty) begin
          ras_top_d = ras_last;
          ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
        end
      end
      if (bp.excp) sepc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q    <= 1'b0;
      for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= 2'b01;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ras_top_q <= '0;
      ras_cnt_q <= '0;
      sepc_q    <= '0;
`ifdef BP_GSHARE_EN
      ghr_q     <= '0;
`endif
    end else begin
      boot_q    <= boot_d;
      pht_q     <= pht_d;
      ras_q     <= ras_d;
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
      sepc_q    <= sepc_d;
`ifdef BP_GSHARE_EN
      ghr_q     <= ghr_d;
`endif
    end
  end

endmodule
